jk_reg_arbiter: RTL and testbench

JK_REG_ARBITER -- requirements
Module: jk_reg_arbiter

---
 rtl/jk_reg_arbiter.sv | 123 ++++++++++++
 tb/tb_jk_reg_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/jk_reg_arbiter.sv
// jk_reg_arbiter: round-robin arbiter serialising JK bit commands onto a
// shared N_BITS register; one command per 3 cycles (IDLE, APPLY, ACK).
// Ports:
//   clk, rst          - clock, async active-high reset
//   req/j_in/k_in     - per-requester request and JK command bits
//   addr_in           - per-requester 3-bit target index, [3i+2:3i]
//   gnt/ack           - one-hot grant (APPLY+ACK) and ack pulse (ACK)
//   q                 - shared JK register
//   busy              - high when not IDLE
module jk_reg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  j_in,
  input  logic [N_REQ-1:0]  k_in,
  input  logic [N_REQ*3-1:0] addr_in,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  ack,
  output logic [N_BITS-1:0] q,
  output logic              busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    ACK
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     last_q, last_d;
  logic              j_q, j_d;
  logic              k_q, k_d;
  logic [2:0]        addr_q, addr_d;
  logic [N_BITS-1:0] q_q, q_d;
  logic              found;

  function automatic int rr_idx(input int l, input int o);
    return (l + o) % N_REQ;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      addr_q  <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      j_q     <= j_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    j_d     = j_q;
    k_d     = k_q;
    addr_d  = addr_q;
    q_d     = q_q;
    found   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // search starts just after the last winner, so it ranks lowest
        for (int o = 1; o <= N_REQ; o++) begin
          if (!found && req[rr_idx(int'(last_q), o)]) begin
            found  = 1'b1;
            win_d  = IW'(rr_idx(int'(last_q), o));
            j_d    = j_in[rr_idx(int'(last_q), o)];
            k_d    = k_in[rr_idx(int'(last_q), o)];
            addr_d = addr_in[3*rr_idx(int'(last_q), o) +: 3];
          end
        end
        if (found) state_d = APPLY;
      end
      APPLY: begin
        // an addr beyond the register matches no bit and changes nothing
        for (int b = 0; b < N_BITS; b++) begin
          if (int'(addr_q) == b) begin
            unique case ({j_q, k_q})
              2'b01:   q_d[b] = 1'b0;
              2'b10:   q_d[b] = 1'b1;
              2'b11:   q_d[b] = ~q_q[b];
              default: q_d[b] = q_q[b];
            endcase
          end
        end
        state_d = ACK;
      end
      ACK: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // decoded from state so an async reset clears them at once
  always_comb begin
    gnt = '0;
    ack = '0;
    if (state_q != IDLE) gnt[win_q] = 1'b1;
    if (state_q == ACK)  ack[win_q] = 1'b1;
  end

  assign q    = q_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// tb_jk_reg_arbiter: directed self-checking bench for jk_reg_arbiter.
// Hand-computed expectations for reset, JK ops, round-robin and abort.
module tb_jk_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  j_in = '0;
  logic [3:0]  k_in = '0;
  logic [11:0] addr_in = '0;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;

  int n_chk = 0;
  int n_ok  = 0;

  jk_reg_arbiter #(.N_REQ(4), .N_BITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .j_in    (j_in),
    .k_in    (k_in),
    .addr_in (addr_in),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input int i, input logic j, input logic k,
                         input logic [2:0] a, input logic [7:0] exp_q);
    req     = 4'(1 << i);
    j_in    = {3'b0, j} << i;
    k_in    = {3'b0, k} << i;
    addr_in = {9'b0, a} << (3 * i);
    step();
    chk("cmd_gnt", 32'(gnt), 32'(1 << i));
    chk("cmd_busy", 32'(busy), 1);
    req = '0;
    j_in = '0;
    k_in = '0;
    step();
    chk("cmd_ack", 32'(ack), 32'(1 << i));
    chk("cmd_q", 32'(q), 32'(exp_q));
    step();
    chk("cmd_idle", 32'(busy), 0);
    chk("cmd_gnt0", 32'(gnt), 0);
  endtask

  initial begin
    #12;
    chk("rst_q", 32'(q), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();
    chk("idle_stay", 32'(busy), 0);

    // set addr 3
    run_cmd(0, 1'b1, 1'b0, 3'd3, 8'h08);
    // toggles and clear
    run_cmd(0, 1'b1, 1'b1, 3'd3, 8'h00);
    run_cmd(0, 1'b1, 1'b1, 3'd0, 8'h01);
    run_cmd(0, 1'b0, 1'b1, 3'd0, 8'h00);
    // addr 7 set, then reset round-robin scenario
    run_cmd(1, 1'b1, 1'b0, 3'd7, 8'h80);

    #2 rst = 1'b1;
    #1 chk("rst2_q", 32'(q), 0);
    rst = 1'b0;
    req = 4'b1111;
    for (int w = 0; w < 4; w++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(1 << w));
      step();
      chk("rr_ack", 32'(ack), 32'(1 << w));
      req[w] = 1'b0;
      step();
      chk("rr_gap", 32'(gnt), 0);
    end

    // q=0x40 via requester 2 (last winner becomes 2)
    run_cmd(2, 1'b1, 1'b0, 3'd6, 8'h40);
    req = 4'b0110;
    j_in = '0;
    k_in = '0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("alt_gnt", 32'(gnt), (n % 2 == 0) ? 32'h2 : 32'h4);
      step();
      chk("alt_ack", 32'(ack), (n % 2 == 0) ? 32'h2 : 32'h4);
      chk("alt_q", 32'(q), 32'h40);
      step();
    end
    req = '0;
    step();

    // async reset mid-APPLY on set addr 5
    rst = 1'b1;
    #2 rst = 1'b0;
    req = 4'b0001;
    j_in = 4'b0001;
    addr_in = 12'd5;
    step();
    chk("ab_gnt", 32'(gnt), 1);
    #2 rst = 1'b1;
    #1;
    chk("ab_gnt0", 32'(gnt), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_q", 32'(q), 0);
    step();
    chk("ab_ack", 32'(ack), 0);
    chk("ab_q2", 32'(q), 0);
    rst = 1'b0;
    step();
    chk("re_gnt", 32'(gnt), 1);
    req = '0;
    step();
    chk("re_ack", 32'(ack), 1);
    chk("re_q", 32'(q), 32'h20);
    step();
    chk("re_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
